// File: rtl/core_link_tx.sv
// Link transmitter: buffers producer words in a small FIFO and emits each as a
// one-cycle fill pulse spaced by a mask gap. Optional macro: CORE_LINK_TX_SENT_CNT_EN.
module core_link_tx #(
  parameter int data_size      = 8,
  parameter int fifo_depth     = 4,
  parameter int mask_cnt_delay = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [data_size-1:0]        s_data,
  input  logic                        hold_i,
  output logic                        fill_o,
  output logic                        empty_o,
  output logic [data_size-1:0]        data_o,
  output logic [$clog2(fifo_depth):0] level_o
`ifdef CORE_LINK_TX_SENT_CNT_EN
  ,
  output logic [15:0]                 sent_cnt_o
`endif
);

  localparam int AW = $clog2(fifo_depth);
  localparam int LW = AW + 1;
  localparam int CW = (mask_cnt_delay == 0) ? 1 : $clog2(mask_cnt_delay + 1);
  localparam logic [CW-1:0] MASK_LOAD = (mask_cnt_delay == 0) ? '0 : CW'(mask_cnt_delay - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(fifo_depth);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    MASK = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [CW-1:0]        r_maskCnt;
  logic [CW-1:0]        w_maskNext;
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [LW-1:0]        r_level;
  logic [data_size-1:0] r_data;
  logic [data_size-1:0] r_mem [fifo_depth];
  logic                 w_push;
  logic                 w_launch;
  logic                 w_canLaunch;

  assign s_ready     = (r_level != FULL_LEVEL);
  assign w_push      = s_valid && s_ready;
  assign w_canLaunch = (r_level != '0) && !hold_i;
  assign fill_o      = (r_state == SEND);
  assign empty_o     = (r_level == '0) && (r_state != SEND);
  assign data_o      = r_data;
  assign level_o     = r_level;

  // Every exit from IDLE, SEND (zero gap) and an expired MASK shares one launch decision
  always_comb begin
    w_stateNext = r_state;
    w_maskNext  = r_maskCnt;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_canLaunch) begin
          w_launch    = 1'b1;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        if (mask_cnt_delay == 0) begin
          if (w_canLaunch) begin
            w_launch    = 1'b1;
            w_stateNext = SEND;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_stateNext = MASK;
          w_maskNext  = MASK_LOAD;
        end
      end
      MASK: begin
        if (r_maskCnt == '0) begin
          if (w_canLaunch) begin
            w_launch    = 1'b1;
            w_stateNext = SEND;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_maskNext = r_maskCnt - CW'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_maskCnt <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_maskCnt <= w_maskNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_launch) begin
        r_rdPtr <= r_rdPtr + AW'(1);
        r_data  <= r_mem[r_rdPtr];
      end
      case ({w_push, w_launch})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the pointers and level define which entries are live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= s_data;
    end
  end

`ifdef CORE_LINK_TX_SENT_CNT_EN
  logic [15:0] r_sentCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sentCnt <= '0;
    end else if (r_state == SEND) begin
      r_sentCnt <= r_sentCnt + 16'd1;
    end
  end

  assign sent_cnt_o = r_sentCnt;
`endif

endmodule

// File: tb/tb_core_link_tx.sv
// Directed bench for core_link_tx: three instances with mask gaps of 1, 0 and 3
// cover single word, burst/full, back-to-back, hold, reset mid-stream and gap spacing.
module tb_core_link_tx;

  logic       clk;
  logic       rst_n;

  logic       aValid, aReady, aHold, aFill, aEmpty;
  logic [7:0] aData, aDout;
  logic [2:0] aLevel;
  logic       bValid, bReady, bHold, bFill, bEmpty;
  logic [7:0] bData, bDout;
  logic [2:0] bLevel;
  logic       cValid, cReady, cHold, cFill, cEmpty;
  logic [7:0] cData, cDout;
  logic [2:0] cLevel;
`ifdef CORE_LINK_TX_SENT_CNT_EN
  logic [15:0] aSentCnt, bSentCnt, cSentCnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  core_link_tx #(.data_size(8), .fifo_depth(4), .mask_cnt_delay(1)) dutA (
    .clk(clk), .rst_n(rst_n), .s_valid(aValid), .s_ready(aReady), .s_data(aData),
    .hold_i(aHold), .fill_o(aFill), .empty_o(aEmpty), .data_o(aDout), .level_o(aLevel)
`ifdef CORE_LINK_TX_SENT_CNT_EN
    , .sent_cnt_o(aSentCnt)
`endif
  );

  core_link_tx #(.data_size(8), .fifo_depth(4), .mask_cnt_delay(0)) dutB (
    .clk(clk), .rst_n(rst_n), .s_valid(bValid), .s_ready(bReady), .s_data(bData),
    .hold_i(bHold), .fill_o(bFill), .empty_o(bEmpty), .data_o(bDout), .level_o(bLevel)
`ifdef CORE_LINK_TX_SENT_CNT_EN
    , .sent_cnt_o(bSentCnt)
`endif
  );

  core_link_tx #(.data_size(8), .fifo_depth(4), .mask_cnt_delay(3)) dutC (
    .clk(clk), .rst_n(rst_n), .s_valid(cValid), .s_ready(cReady), .s_data(cData),
    .hold_i(cHold), .fill_o(cFill), .empty_o(cEmpty), .data_o(cDout), .level_o(cLevel)
`ifdef CORE_LINK_TX_SENT_CNT_EN
    , .sent_cnt_o(cSentCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    aValid = 1'b0; aData = 8'h00; aHold = 1'b0;
    bValid = 1'b0; bData = 8'h00; bHold = 1'b0;
    cValid = 1'b0; cData = 8'h00; cHold = 1'b0;
    step();
    step();

    checkOutput("reset_fill", aFill, 1'b0);
    checkOutput("reset_data", aDout, 8'h00);
    checkOutput("reset_empty", aEmpty, 1'b1);
    checkOutput("reset_ready", aReady, 1'b1);
    checkOutput("reset_level", aLevel, 3'd0);
    rst_n = 1'b1;
    step();

    // Single word with a one-cycle gap
    aValid = 1'b1; aData = 8'hA5;
    step();
    aValid = 1'b0;
    checkOutput("single_level_after_push", aLevel, 3'd1);
    checkOutput("single_empty_after_push", aEmpty, 1'b0);
    checkOutput("single_fill_before_launch", aFill, 1'b0);
    step();
    checkOutput("single_fill", aFill, 1'b1);
    checkOutput("single_data", aDout, 8'hA5);
    checkOutput("single_empty_in_send", aEmpty, 1'b0);
    step();
    checkOutput("single_fill_gap", aFill, 1'b0);
    checkOutput("single_empty_drained", aEmpty, 1'b1);
    checkOutput("single_data_held", aDout, 8'hA5);
    step();
    checkOutput("single_fill_idle", aFill, 1'b0);

    // Burst under hold until full, then release
    aHold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      aValid = 1'b1; aData = 8'(i);
      step();
    end
    checkOutput("burst_full_level", aLevel, 3'd4);
    checkOutput("burst_full_ready", aReady, 1'b0);
    aHold = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k % 2 == 1) begin
        checkOutput($sformatf("burst_fill_k%0d", k), aFill, 1'b1);
        checkOutput($sformatf("burst_data_k%0d", k), aDout, 32'((k + 1) / 2));
      end else begin
        checkOutput($sformatf("burst_gap_k%0d", k), aFill, 1'b0);
      end
      if (k == 1) checkOutput("burst_ready_after_pop", aReady, 1'b1);
      if (k == 2) begin
        checkOutput("burst_level_after_refill", aLevel, 3'd4);
        aValid = 1'b0;
      end
    end
    checkOutput("burst_empty_end", aEmpty, 1'b1);
    step();

    // Hold raised during SEND: pulse and gap complete, launch waits for release
    aValid = 1'b1; aData = 8'h3C;
    step();
    checkOutput("hold_level_first", aLevel, 3'd1);
    aData = 8'h3D;
    step();
    checkOutput("hold_fill_first", aFill, 1'b1);
    checkOutput("hold_data_first", aDout, 8'h3C);
    checkOutput("hold_level_push_pop", aLevel, 3'd1);
    aValid = 1'b0; aHold = 1'b1;
    step();
    checkOutput("hold_mask", aFill, 1'b0);
    step();
    checkOutput("hold_blocked_1", aFill, 1'b0);
    checkOutput("hold_level_kept", aLevel, 3'd1);
    step();
    checkOutput("hold_blocked_2", aFill, 1'b0);
    aHold = 1'b0;
    step();
    checkOutput("hold_release_fill", aFill, 1'b1);
    checkOutput("hold_release_data", aDout, 8'h3D);
    step();
    step();
    checkOutput("hold_drained", aEmpty, 1'b1);

    // Reset with three queued words and one in SEND
    aHold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aValid = 1'b1; aData = 8'h11 + 8'(i);
      step();
    end
    aValid = 1'b0; aHold = 1'b0;
    step();
    checkOutput("rst_mid_fill", aFill, 1'b1);
    checkOutput("rst_mid_data", aDout, 8'h11);
    checkOutput("rst_mid_level", aLevel, 3'd3);
    rst_n = 1'b0;
    step();
    checkOutput("rst_after_fill", aFill, 1'b0);
    checkOutput("rst_after_level", aLevel, 3'd0);
    checkOutput("rst_after_empty", aEmpty, 1'b1);
    checkOutput("rst_after_data", aDout, 8'h00);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput($sformatf("rst_no_stale_k%0d", k), aFill, 1'b0);
    end
    checkOutput("rst_still_empty", aEmpty, 1'b1);

    // Zero gap: back-to-back pulses
    bHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bValid = 1'b1; bData = 8'h21 + 8'(i);
      step();
    end
    bValid = 1'b0; bHold = 1'b0;
    checkOutput("b2b_level_queued", bLevel, 3'd3);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k <= 3) begin
        checkOutput($sformatf("b2b_fill_k%0d", k), bFill, 1'b1);
        checkOutput($sformatf("b2b_data_k%0d", k), bDout, 32'(8'h20 + k));
      end else begin
        checkOutput("b2b_fill_end", bFill, 1'b0);
        checkOutput("b2b_empty_end", bEmpty, 1'b1);
      end
    end

    // Three-cycle gap: pulses four cycles apart
    cHold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cValid = 1'b1; cData = 8'h31 + 8'(i);
      step();
    end
    cValid = 1'b0; cHold = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checkOutput($sformatf("gap3_fill_k%0d", k), cFill, (k == 1 || k == 5) ? 1'b1 : 1'b0);
      if (k == 1) checkOutput("gap3_data_first", cDout, 8'h31);
      if (k == 5) checkOutput("gap3_data_second", cDout, 8'h32);
    end
    checkOutput("gap3_empty_end", cEmpty, 1'b1);

`ifdef CORE_LINK_TX_SENT_CNT_EN
    checkOutput("cnt_b_three_sent", bSentCnt, 16'd3);
    checkOutput("cnt_c_two_sent", cSentCnt, 16'd2);
    checkOutput("cnt_a_after_reset", aSentCnt, 16'd0);
    aValid = 1'b1; aData = 8'h55;
    step();
    aValid = 1'b0;
    step();
    checkOutput("cnt_a_fill", aFill, 1'b1);
    step();
    checkOutput("cnt_a_one_sent", aSentCnt, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
